// File: rtl/conv3x3_window_mac.sv
// 3x3 valid-padding, stride-1 convolution engine: one output pixel per accepted
// pulse_start, fetched from synchronous-read pixel/weight memories, raster-ordered.
//
//  state | meaning
//  IDLE  | waiting for pulse_start
//  FETCH | issuing reads for taps k=0..8
//  DRAIN | last tap's data in flight, final accumulate
//  HOLD  | result presented, waiting for out_ready
module conv3x3_window_mac #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pulse_start,
  output logic                     pix_rd_en,
  output logic [ADDR_W-1:0]        pix_addr,
  input  logic signed [DATA_W-1:0] pix_data,
  output logic [3:0]               w_addr,
  input  logic signed [DATA_W-1:0] w_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic [7:0]               out_row,
  output logic [7:0]               out_col,
  output logic                     frame_done,
  output logic                     overrun
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

  state_t state, state_nxt;

  logic [3:0] k;
  logic [1:0] ki, kj;
  logic [7:0] row, col;
  logic signed [ACC_W-1:0] acc;
  logic acc_en;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0] prod_ext, sum;
  logic handshake, last_col, last_row;

  assign prod      = pix_data * w_data;
  assign prod_ext  = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign sum       = acc + prod_ext;
  assign handshake = (state == HOLD) && out_valid && out_ready;
  assign last_col  = (col == 8'(IMG_W-3));
  assign last_row  = (row == 8'(IMG_H-3));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pix_rd_en = 1'b0;
    pix_addr  = '0;
    w_addr    = '0;
    case (state)
      IDLE:  if (pulse_start) state_nxt = FETCH;
      FETCH: begin
        pix_rd_en = 1'b1;
        w_addr    = k;
        pix_addr  = ADDR_W'((int'(row) + int'(ki)) * IMG_W + int'(col) + int'(kj));
        if (k == 4'd8) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = HOLD;
      HOLD:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k          <= '0;
      ki         <= '0;
      kj         <= '0;
      row        <= '0;
      col        <= '0;
      acc        <= '0;
      acc_en     <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // Read data trails its issue cycle by one, so accumulation is delayed to match.
      acc_en     <= (state == FETCH);
      frame_done <= 1'b0;
      if (acc_en) acc <= sum;

      if (state == IDLE && pulse_start) begin
        k   <= '0;
        ki  <= '0;
        kj  <= '0;
        acc <= '0;
      end

      if (state == FETCH) begin
        k <= k + 4'd1;
        if (kj == 2'd2) begin
          kj <= '0;
          ki <= ki + 2'd1;
        end else begin
          kj <= kj + 2'd1;
        end
      end

      if (state == DRAIN) begin
        out_data  <= sum;
        out_valid <= 1'b1;
        out_row   <= row;
        out_col   <= col;
      end

      if (handshake) begin
        out_valid <= 1'b0;
        if (last_col) begin
          col <= '0;
          if (last_row) begin
            row        <= '0;
            frame_done <= 1'b1;
          end else begin
            row <= row + 8'd1;
          end
        end else begin
          col <= col + 8'd1;
        end
      end

      if (pulse_start && state != IDLE) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv3x3_window_mac.sv
// Directed, self-checking bench for conv3x3_window_mac on a 4x4 image,
// with synchronous-read pixel and weight memory models.
module tb_conv3x3_window_mac;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;
  localparam int ADDR_W = 4;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     pulse_start = 1'b0;
  logic                     pix_rd_en;
  logic [ADDR_W-1:0]        pix_addr;
  logic signed [DATA_W-1:0] pix_data = '0;
  logic [3:0]               w_addr;
  logic signed [DATA_W-1:0] w_data = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic signed [ACC_W-1:0]  out_data;
  logic [7:0]               out_row;
  logic [7:0]               out_col;
  logic                     frame_done;
  logic                     overrun;

  int checks = 0;
  int errors = 0;

  logic signed [DATA_W-1:0] pix_mem [16];
  logic signed [DATA_W-1:0] w_mem   [9];

  conv3x3_window_mac #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .pulse_start(pulse_start),
    .pix_rd_en(pix_rd_en), .pix_addr(pix_addr), .pix_data(pix_data),
    .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pix_rd_en) begin
      pix_data <= pix_mem[pix_addr];
      w_data   <= (w_addr < 4'd9) ? w_mem[w_addr] : 8'sd0;
    end
  end

  task automatic load_mem(input int mode);
    for (int i = 0; i < 16; i++)
      pix_mem[i] = (mode == 0) ? 8'sd1 : (mode == 1) ? -8'sd128 : 8'(i);
    for (int i = 0; i < 9; i++)
      w_mem[i] = (mode == 1) ? 8'sd127 : 8'sd1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    pulse_start = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Ends 1 time unit after the edge that sampled the pulse.
  task automatic do_pulse();
    @(negedge clk);
    pulse_start = 1'b1;
    @(posedge clk);
    #1 pulse_start = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      #1 edges++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++;
    if ({pix_rd_en, pix_addr, w_addr, out_valid, out_data, out_row, out_col, frame_done, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%b addr=%0d w=%0d v=%b d=%0d r=%0d c=%0d fd=%b ov=%b, want all 0",
               pix_rd_en, pix_addr, w_addr, out_valid, out_data, out_row, out_col, frame_done, overrun);
    end
    apply_reset();
  endtask

  task automatic test_basic();
    int edges;
    load_mem(0);
    apply_reset();
    out_ready = 1'b1;
    do_pulse();
    wait_valid(edges);
    checks++;
    if (edges !== 10) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges, want 10", edges);
    end
    checks++;
    if (out_data !== 24'sd9 || out_row !== 8'd0 || out_col !== 8'd0) begin
      errors++;
      $display("FAIL basic_result: got %0d at (%0d,%0d), want 9 at (0,0)", out_data, out_row, out_col);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_handshake: out_valid got %b, want 0", out_valid);
    end
  endtask

  task automatic test_raster();
    int edges;
    logic [7:0] exp_r [5] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd0};
    logic [7:0] exp_c [5] = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0};
    logic       fd;
    load_mem(0);
    apply_reset();
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      do_pulse();
      wait_valid(edges);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 24'sd9 || out_row !== exp_r[n] || out_col !== exp_c[n]) begin
        errors++;
        $display("FAIL raster_pos%0d: got v=%b %0d at (%0d,%0d), want 9 at (%0d,%0d)",
                 n, out_valid, out_data, out_row, out_col, exp_r[n], exp_c[n]);
      end
      @(posedge clk);
      #1 fd = frame_done;
      checks++;
      if (fd !== (n == 3)) begin
        errors++;
        $display("FAIL raster_frame_done%0d: got %b, want %b", n, fd, (n == 3));
      end
      @(posedge clk);
      #1;
      checks++;
      if (frame_done !== 1'b0) begin
        errors++;
        $display("FAIL raster_frame_done_width%0d: got %b, want 0", n, frame_done);
      end
      repeat (3) @(posedge clk);
    end
  endtask

  task automatic test_arith();
    int edges;
    load_mem(1);
    apply_reset();
    out_ready = 1'b1;
    do_pulse();
    wait_valid(edges);
    checks++;
    if (out_data !== -24'sd146304) begin
      errors++;
      $display("FAIL arith_neg: got %0d, want -146304", out_data);
    end
    repeat (3) @(posedge clk);
    load_mem(2);
    apply_reset();
    out_ready = 1'b1;
    do_pulse();
    wait_valid(edges);
    checks++;
    if (out_data !== 24'sd45 || out_row !== 8'd0 || out_col !== 8'd0) begin
      errors++;
      $display("FAIL arith_ramp00: got %0d at (%0d,%0d), want 45 at (0,0)", out_data, out_row, out_col);
    end
    repeat (3) @(posedge clk);
    for (int n = 0; n < 2; n++) begin
      do_pulse();
      wait_valid(edges);
      repeat (3) @(posedge clk);
    end
    do_pulse();
    wait_valid(edges);
    checks++;
    if (out_data !== 24'sd90 || out_row !== 8'd1 || out_col !== 8'd1) begin
      errors++;
      $display("FAIL arith_ramp11: got %0d at (%0d,%0d), want 90 at (1,1)", out_data, out_row, out_col);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_backpressure();
    int edges;
    load_mem(2);
    apply_reset();
    out_ready = 1'b0;
    do_pulse();
    wait_valid(edges);
    for (int n = 0; n < 20; n++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 24'sd45 || out_row !== 8'd0 || out_col !== 8'd0) begin
        errors++;
        $display("FAIL hold_cycle%0d: got v=%b %0d at (%0d,%0d), want v=1 45 at (0,0)",
                 n, out_valid, out_data, out_row, out_col);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: out_valid got %b, want 0", out_valid);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || pix_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: got v=%b rd=%b, want 0 0", out_valid, pix_rd_en);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_overrun();
    int edges;
    load_mem(0);
    apply_reset();
    out_ready = 1'b1;
    do_pulse();
    @(posedge clk);
    #1 pulse_start = 1'b1;
    @(posedge clk);
    #1 pulse_start = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_fetch: got %b, want 1", overrun);
    end
    wait_valid(edges);
    checks++;
    if (out_data !== 24'sd9 || out_row !== 8'd0 || out_col !== 8'd0) begin
      errors++;
      $display("FAIL overrun_fetch_result: got %0d at (%0d,%0d), want 9 at (0,0)", out_data, out_row, out_col);
    end
    repeat (3) @(posedge clk);

    apply_reset();
    out_ready = 1'b0;
    do_pulse();
    wait_valid(edges);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clean: got %b, want 0", overrun);
    end
    @(negedge clk);
    pulse_start = 1'b1;
    @(negedge clk);
    pulse_start = 1'b0;
    checks++;
    if (overrun !== 1'b1 || out_valid !== 1'b1 || out_data !== 24'sd9) begin
      errors++;
      $display("FAIL overrun_hold: got ov=%b v=%b d=%0d, want 1 1 9", overrun, out_valid, out_data);
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    do_pulse();
    wait_valid(edges);
    checks++;
    if (overrun !== 1'b1 || out_data !== 24'sd9 || out_row !== 8'd0 || out_col !== 8'd1) begin
      errors++;
      $display("FAIL overrun_sticky: got ov=%b %0d at (%0d,%0d), want 1 9 at (0,1)",
               overrun, out_data, out_row, out_col);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_midfetch();
    int edges;
    load_mem(2);
    apply_reset();
    out_ready = 1'b1;
    do_pulse();
    @(posedge clk);
    #1 pulse_start = 1'b1;
    @(posedge clk);
    #1 pulse_start = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({pix_rd_en, pix_addr, w_addr, out_valid, out_data, out_row, out_col, frame_done, overrun} !== '0) begin
      errors++;
      $display("FAIL midfetch_reset: got rd=%b addr=%0d w=%0d v=%b d=%0d ov=%b, want all 0",
               pix_rd_en, pix_addr, w_addr, out_valid, out_data, overrun);
    end
    @(negedge clk);
    reset = 1'b0;
    do_pulse();
    wait_valid(edges);
    checks++;
    if (edges !== 10 || out_data !== 24'sd45 || out_row !== 8'd0 || out_col !== 8'd0) begin
      errors++;
      $display("FAIL midfetch_recover: got %0d edges, %0d at (%0d,%0d), want 10, 45 at (0,0)",
               edges, out_data, out_row, out_col);
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    load_mem(0);
    test_reset();
    test_basic();
    test_raster();
    test_arith();
    test_backpressure();
    test_overrun();
    test_reset_midfetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
